// File: rtl/mult_div_ctrl.sv
// Multicycle MULT/DIV sequencer: signed radix-2 Booth multiply and signed restoring divide,
// with a start/busy/done handshake and one-cycle HI/LO write strobes.
module mult_div_ctrl #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_mult,
   input  logic              start_div,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              busy,
   output logic              done,
   output logic              div_zero,
   output logic [DATA_W-1:0] hi_out,
   output logic [DATA_W-1:0] lo_out,
   output logic              hi_w,
   output logic              lo_w
);

   localparam int unsigned ACC_W = DATA_W + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [DATA_W-1:0] q_q, q_d;
   logic              qm1_q, qm1_d;
   logic [DATA_W-1:0] m_q, m_d;
   logic              neg_quo_q, neg_quo_d;
   logic              neg_rem_q, neg_rem_d;
   logic              dz_q, dz_d;
   logic [DATA_W-1:0] hi_d, lo_d;
   logic              busy_d, done_d, div_zero_d, wr_d;

   logic [ACC_W-1:0]        m_ext;
   logic [ACC_W-1:0]        booth_sum;
   logic [ACC_W+DATA_W:0]   booth_sh;
   logic [DATA_W-1:0]       rem_sh;
   logic [DATA_W:0]         trial;
   logic [DATA_W-1:0]       rem_n;
   logic [DATA_W-1:0]       quo_n;

   // Next-state, datapath step and registered-output values
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      q_d       = q_q;
      qm1_d     = qm1_q;
      m_d       = m_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      dz_d      = dz_q;
      hi_d      = hi_out;
      lo_d      = lo_out;

      // Booth step: add/subtract sign-extended M, then arithmetic shift {acc, Q} right
      m_ext = {m_q[DATA_W-1], m_q};
      unique case ({q_q[0], qm1_q})
         2'b01:   booth_sum = acc_q + m_ext;
         2'b10:   booth_sum = acc_q - m_ext;
         default: booth_sum = acc_q;
      endcase
      booth_sh = {booth_sum[ACC_W-1], booth_sum, q_q};

      // Restoring step on magnitudes; partial remainder stays below the divisor
      rem_sh = {acc_q[DATA_W-2:0], q_q[DATA_W-1]};
      trial  = {1'b0, rem_sh} - {1'b0, m_q};
      if (trial[DATA_W]) begin
         rem_n = rem_sh;
         quo_n = {q_q[DATA_W-2:0], 1'b0};
      end else begin
         rem_n = trial[DATA_W-1:0];
         quo_n = {q_q[DATA_W-2:0], 1'b1};
      end

      unique case (state_q)
         S_IDLE: begin
            if (start_mult) begin
               state_d = S_MULT;
               cnt_d   = '0;
               acc_d   = '0;
               q_d     = b;
               qm1_d   = 1'b0;
               m_d     = a;
               dz_d    = 1'b0;
            end else if (start_div) begin
               if (b == '0) begin
                  state_d = S_DONE;
                  dz_d    = 1'b1;
               end else begin
                  state_d   = S_DIV;
                  cnt_d     = '0;
                  acc_d     = '0;
                  q_d       = a[DATA_W-1] ? DATA_W'(0) - a : a;
                  m_d       = b[DATA_W-1] ? DATA_W'(0) - b : b;
                  neg_quo_d = a[DATA_W-1] ^ b[DATA_W-1];
                  neg_rem_d = a[DATA_W-1];
                  dz_d      = 1'b0;
               end
            end
         end
         S_MULT: begin
            acc_d = booth_sh[ACC_W+DATA_W -: ACC_W];
            q_d   = booth_sh[DATA_W:1];
            qm1_d = booth_sh[0];
            if (cnt_q == LAST_CNT) begin
               state_d = S_DONE;
               hi_d    = booth_sh[ACC_W+DATA_W-1 -: DATA_W];
               lo_d    = booth_sh[DATA_W:1];
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DIV: begin
            acc_d = {1'b0, rem_n};
            q_d   = quo_n;
            if (cnt_q == LAST_CNT) begin
               state_d = S_DONE;
               lo_d    = neg_quo_q ? DATA_W'(0) - quo_n : quo_n;
               hi_d    = neg_rem_q ? DATA_W'(0) - rem_n : rem_n;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            dz_d    = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase

      busy_d     = (state_d == S_MULT) || (state_d == S_DIV);
      done_d     = (state_d == S_DONE);
      div_zero_d = done_d && dz_d;
      wr_d       = done_d && !dz_d;
   end

   // State, datapath and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         q_q       <= '0;
         qm1_q     <= 1'b0;
         m_q       <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
         hi_out    <= '0;
         lo_out    <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         div_zero  <= 1'b0;
         hi_w      <= 1'b0;
         lo_w      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         q_q       <= q_d;
         qm1_q     <= qm1_d;
         m_q       <= m_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         dz_q      <= dz_d;
         hi_out    <= hi_d;
         lo_out    <= lo_d;
         busy      <= busy_d;
         done      <= done_d;
         div_zero  <= div_zero_d;
         hi_w      <= wr_d;
         lo_w      <= wr_d;
      end
   end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Directed bench for mult_div_ctrl: hand-computed products/quotients, latency, handshake and abort cases.
module tb_mult_div_ctrl;

   logic        clk;
   logic        reset;
   logic        start_mult;
   logic        start_div;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic        div_zero;
   logic [31:0] hi_out;
   logic [31:0] lo_out;
   logic        hi_w;
   logic        lo_w;

   int checks = 0;
   int errors = 0;

   mult_div_ctrl #(.DATA_W(32), .CNT_W(6)) dut (
      .clk        (clk),
      .reset      (reset),
      .start_mult (start_mult),
      .start_div  (start_div),
      .a          (a),
      .b          (b),
      .busy       (busy),
      .done       (done),
      .div_zero   (div_zero),
      .hi_out     (hi_out),
      .lo_out     (lo_out),
      .hi_w       (hi_w),
      .lo_w       (lo_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive a start request for one edge, then scramble operands
   task automatic start_op(input logic sm, input logic sd, input logic [31:0] av, input logic [31:0] bv);
      @(negedge clk);
      start_mult = sm;
      start_div  = sd;
      a          = av;
      b          = bv;
      @(posedge clk);
      #1;
      start_mult = 1'b0;
      start_div  = 1'b0;
      a          = $urandom;
      b          = $urandom;
   endtask

   // Bounded wait for done, counting negedges after the start edge and busy cycles
   task automatic wait_done(output int lat, output int busy_cnt, output bit ok);
      lat = 0;
      busy_cnt = 0;
      ok = 1'b0;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         if (done) begin
            lat = i;
            ok  = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      checks++;
      if ({busy, done, div_zero, hi_w, lo_w} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 00000", {busy, done, div_zero, hi_w, lo_w});
      end
      checks++;
      if (hi_out !== 32'h0 || lo_out !== 32'h0) begin
         errors++;
         $display("FAIL reset_data: got %h_%h expected 0_0", hi_out, lo_out);
      end
   endtask

   task automatic test_mult();
      logic [31:0] va [4] = '{32'h0000_0007, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFB};
      logic [31:0] vb [4] = '{32'hFFFF_FFFD, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFA};
      logic [31:0] eh [4] = '{32'hFFFF_FFFF, 32'h3FFF_FFFF, 32'h4000_0000, 32'h0000_0000};
      logic [31:0] el [4] = '{32'hFFFF_FFEB, 32'h0000_0001, 32'h0000_0000, 32'h0000_001E};
      int lat, bc;
      bit ok;
      for (int i = 0; i < 4; i++) begin
         start_op(1'b1, 1'b0, va[i], vb[i]);
         wait_done(lat, bc, ok);
         checks++;
         if (!ok || lat != 33) begin
            errors++;
            $display("FAIL mult[%0d] latency: got %0d (seen=%0b) expected 33", i, lat, ok);
         end
         checks++;
         if (bc != 32) begin
            errors++;
            $display("FAIL mult[%0d] busy_cycles: got %0d expected 32", i, bc);
         end
         checks++;
         if ({hi_w, lo_w, div_zero, busy} !== 4'b1100) begin
            errors++;
            $display("FAIL mult[%0d] strobes: got %b expected 1100", i, {hi_w, lo_w, div_zero, busy});
         end
         checks++;
         if (hi_out !== eh[i] || lo_out !== el[i]) begin
            errors++;
            $display("FAIL mult[%0d] result: got %h_%h expected %h_%h", i, hi_out, lo_out, eh[i], el[i]);
         end
         @(negedge clk);
         checks++;
         if ({done, hi_w, lo_w} !== 3'b000 || hi_out !== eh[i] || lo_out !== el[i]) begin
            errors++;
            $display("FAIL mult[%0d] after_done: got done/w=%b hi=%h lo=%h expected 000 %h %h",
                     i, {done, hi_w, lo_w}, hi_out, lo_out, eh[i], el[i]);
         end
      end
   endtask

   task automatic test_div();
      logic [31:0] va [4] = '{32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'd7};
      logic [31:0] vb [4] = '{32'd2, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
      logic [31:0] eh [4] = '{32'hFFFF_FFFF, 32'd2, 32'h0000_0000, 32'd1};
      logic [31:0] el [4] = '{32'hFFFF_FFFD, 32'd14, 32'h8000_0000, 32'hFFFF_FFFD};
      int lat, bc;
      bit ok;
      for (int i = 0; i < 4; i++) begin
         start_op(1'b0, 1'b1, va[i], vb[i]);
         wait_done(lat, bc, ok);
         checks++;
         if (!ok || lat != 33 || bc != 32) begin
            errors++;
            $display("FAIL div[%0d] timing: got lat=%0d busy=%0d expected 33/32", i, lat, bc);
         end
         checks++;
         if ({hi_w, lo_w, div_zero} !== 3'b110) begin
            errors++;
            $display("FAIL div[%0d] strobes: got %b expected 110", i, {hi_w, lo_w, div_zero});
         end
         checks++;
         if (hi_out !== eh[i] || lo_out !== el[i]) begin
            errors++;
            $display("FAIL div[%0d] result: got rem=%h quo=%h expected rem=%h quo=%h",
                     i, hi_out, lo_out, eh[i], el[i]);
         end
         @(negedge clk);
      end
   endtask

   // Previous result was 7 / -2 -> HI=1, LO=0xFFFFFFFD; it must survive the abort
   task automatic test_div_zero();
      int lat, bc;
      bit ok;
      start_op(1'b0, 1'b1, 32'd5, 32'd0);
      wait_done(lat, bc, ok);
      checks++;
      if (!ok || lat != 1 || bc != 0) begin
         errors++;
         $display("FAIL divzero timing: got lat=%0d busy=%0d expected 1/0", lat, bc);
      end
      checks++;
      if ({div_zero, hi_w, lo_w} !== 3'b100) begin
         errors++;
         $display("FAIL divzero strobes: got %b expected 100", {div_zero, hi_w, lo_w});
      end
      checks++;
      if (hi_out !== 32'd1 || lo_out !== 32'hFFFF_FFFD) begin
         errors++;
         $display("FAIL divzero hold: got %h_%h expected 00000001_fffffffd", hi_out, lo_out);
      end
      @(negedge clk);
      checks++;
      if ({done, div_zero, busy} !== 3'b000) begin
         errors++;
         $display("FAIL divzero after: got %b expected 000", {done, div_zero, busy});
      end
   endtask

   task automatic test_priority();
      int lat, bc;
      bit ok;
      start_op(1'b1, 1'b1, 32'd3, 32'd4);
      wait_done(lat, bc, ok);
      checks++;
      if (!ok || hi_out !== 32'd0 || lo_out !== 32'd12 || div_zero !== 1'b0) begin
         errors++;
         $display("FAIL priority: got hi=%h lo=%h dz=%b expected 0 c 0", hi_out, lo_out, div_zero);
      end
      @(negedge clk);
   endtask

   task automatic test_ignore_start();
      int lat, bc;
      bit ok;
      start_op(1'b1, 1'b0, 32'd6, 32'd5);
      repeat (4) @(negedge clk);
      start_div = 1'b1;
      a = 32'd100;
      b = 32'd0;
      @(negedge clk);
      start_div = 1'b0;
      wait_done(lat, bc, ok);
      checks++;
      if (!ok || lat != 28 || hi_out !== 32'd0 || lo_out !== 32'd30 || div_zero !== 1'b0) begin
         errors++;
         $display("FAIL ignore_start: got lat=%0d hi=%h lo=%h dz=%b expected 28 0 1e 0",
                  lat, hi_out, lo_out, div_zero);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int lat, bc;
      bit ok;
      bit wr_seen;
      start_op(1'b1, 1'b0, 32'd9, 32'd9);
      repeat (10) @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if ({busy, done, div_zero, hi_w, lo_w} !== 5'b0 || hi_out !== 32'd0 || lo_out !== 32'd0) begin
         errors++;
         $display("FAIL reset_mid: got flags=%b hi=%h lo=%h expected 0", {busy, done, div_zero, hi_w, lo_w},
                  hi_out, lo_out);
      end
      @(negedge clk);
      reset = 1'b1;
      wr_seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (hi_w || lo_w || done || busy) wr_seen = 1'b1;
      end
      checks++;
      if (wr_seen) begin
         errors++;
         $display("FAIL reset_mid idle: got activity=1 expected 0");
      end
      start_op(1'b1, 1'b0, 32'd2, 32'd3);
      wait_done(lat, bc, ok);
      checks++;
      if (!ok || lat != 33 || lo_out !== 32'd6 || hi_out !== 32'd0) begin
         errors++;
         $display("FAIL reset_mid restart: got lat=%0d hi=%h lo=%h expected 33 0 6", lat, hi_out, lo_out);
      end
   endtask

   // Start held during the DONE cycle is dropped; the next cycle's start is taken
   task automatic test_back_to_back();
      int lat, bc;
      bit ok;
      start_op(1'b1, 1'b0, 32'd10, 32'd10);
      wait_done(lat, bc, ok);
      start_mult = 1'b1;
      a = 32'd11;
      b = 32'd11;
      @(negedge clk);
      start_mult = 1'b0;
      checks++;
      if (!ok || busy !== 1'b0 || lo_out !== 32'd100) begin
         errors++;
         $display("FAIL b2b drop: got busy=%b lo=%h expected 0 64", busy, lo_out);
      end
      start_mult = 1'b1;
      a = 32'd12;
      b = 32'd12;
      @(posedge clk);
      #1;
      start_mult = 1'b0;
      wait_done(lat, bc, ok);
      checks++;
      if (!ok || lat != 33 || lo_out !== 32'd144) begin
         errors++;
         $display("FAIL b2b accept: got lat=%0d lo=%h expected 33 90", lat, lo_out);
      end
      @(negedge clk);
   endtask

   initial begin
      reset      = 1'b0;
      start_mult = 1'b0;
      start_div  = 1'b0;
      a          = 32'h0;
      b          = 32'h0;
      repeat (2) @(negedge clk);
      test_reset();
      reset = 1'b1;
      @(negedge clk);
      test_mult();
      test_div();
      test_div_zero();
      test_priority();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mult_div_ctrl.md
Name: mult_div_ctrl

Overview:
- Multicycle sequencer for the MULT/DIV instructions of the multicycle CPU.
- Takes the A/B register operands, iterates a signed radix-2 Booth multiply or a signed restoring divide, and drives the HI/LO write strobes and result buses.
- Exposes a start/busy/done handshake so the main control unit can hold in a wait state until done.

Parameters:
- DATA_W, 32, operand width; also the iteration count (HI and LO are DATA_W each).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start_mult  in  1  one-cycle request: signed multiply a*b.
- start_div  in  1  one-cycle request: signed divide a/b.
- a  in  DATA_W  operand A (multiplicand / dividend), from register A.
- b  in  DATA_W  operand B (multiplier / divisor), from register B.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse; operation finished (including the divide-by-zero abort).
- div_zero  out  1  one-cycle pulse together with done when the divisor is 0.
- hi_out  out  DATA_W  result for HI: product[63:32] or remainder.
- lo_out  out  DATA_W  result for LO: product[31:0] or quotient.
- hi_w  out  1  HI register write enable, one-cycle pulse.
- lo_w  out  1  LO register write enable, one-cycle pulse.

Behaviour:
- Reset (asserted low, asynchronous): state IDLE; counter, internal accumulators, hi_out and lo_out cleared to 0; busy, done, div_zero, hi_w and lo_w all 0.
- States: IDLE, MULT, DIV, DONE.
- IDLE:
  - Samples the start inputs on the rising edge; operands a and b are latched on that same edge.
  - start_mult and start_div both high: multiply wins.
  - start_div with b==0: go directly to DONE with the div_zero flag set; no iterations run.
  - Otherwise go to MULT or DIV with counter=0.
  - busy=0 in IDLE.
- MULT:
  - One Booth step per cycle: examine {Q[0], Q-1}; add or subtract M into the upper half; arithmetic-shift the {acc, Q, Q-1} right by 1.
  - After DATA_W steps (counter==DATA_W-1 on that edge), go to DONE.
- DIV:
  - Operands are converted to magnitudes on entry; one restoring step per cycle (shift, trial subtract, restore if negative).
  - After DATA_W steps, go to DONE, applying sign correction on that same edge.
  - Quotient is truncated toward zero; its sign is sign(a) XOR sign(b).
  - Remainder takes the sign of a.
  - 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000, remainder 0 (wraps, no trap).
- DONE:
  - Lasts exactly one cycle; done=1 and busy=0.
  - Normal completion: hi_w=lo_w=1, and hi_out/lo_out carry the results.
  - Divide-by-zero: div_zero=1, hi_w=lo_w=0, and hi_out/lo_out keep their previous values.
  - Next state is IDLE.
- busy=1 in MULT and DIV only.
- hi_out/lo_out are registered and hold their last value until the next completed operation.
- Latency:
  - Start sampled at edge E0; iterations occur on E1..E32; done is high during the cycle following E32, i.e. 33 cycles after the start edge.
  - Divide-by-zero: done is high in the cycle right after E0.
  - Back-to-back: a new start is accepted on the edge that leaves DONE is not allowed; the earliest accepted start is the cycle after done.
- Start inputs asserted while busy or in DONE are ignored; they are neither queued nor allowed to corrupt the operand registers.
- Operand inputs a and b may change freely after the start edge.
- Reset asserted mid-operation aborts immediately to reset values; no hi_w/lo_w pulse is produced.
- The counter never exceeds DATA_W-1; no wrap-around is reachable.

Test Plan:
- Multiply a=7, b=0xFFFFFFFD (-3) -> 33 cycles after start: done=1, hi_w=lo_w=1 for one cycle, hi_out=0xFFFFFFFF, lo_out=0xFFFFFFEB; busy high for exactly 32 cycles.
- Multiply a=b=0x7FFFFFFF -> hi_out=0x3FFFFFFF, lo_out=0x00000001. Multiply a=b=0x80000000 -> hi_out=0x40000000, lo_out=0.
- Divide a=0xFFFFFFF9 (-7), b=2 -> lo_out=0xFFFFFFFD (-3), hi_out=0xFFFFFFFF (-1). Divide a=100, b=7 -> lo_out=14, hi_out=2.
- Divide a=5, b=0 -> next cycle done=div_zero=1, hi_w=lo_w=0, hi_out/lo_out unchanged, busy never asserted.
- Divide a=0x80000000, b=0xFFFFFFFF -> lo_out=0x80000000, hi_out=0. Assert start_mult and start_div together with a=3, b=4 -> multiply result hi_out=0, lo_out=12.
- Start a multiply, pulse start_div with new operands at iteration 5 -> ignored, multiply result correct. Start a multiply, drive reset low at iteration 10 -> all outputs 0, state IDLE, no write pulse; next start completes normally.
